// File: rtl/battle_front.sv
// battle_front: per-tick combat sequencer for the enemy slot array.
// Each round scans the slots for the frontmost live enemy, strobes every
// live enemy to move, sums the damage they report (saturating at 255), and
// then strikes the chosen front enemy with the player's damage.
// Every output is taken from a register and never directly from an input.

module battle_front #(
   parameter int N_ENEMY = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   gameTick,
   input  logic [8:0]             playerFront,
   input  logic [7:0]             playerDamage,
   input  logic [9*N_ENEMY-1:0]   enemyPos,
   input  logic [8*N_ENEMY-1:0]   enemyDmg,
   input  logic [2*N_ENEMY-1:0]   enemyType,
   output logic [N_ENEMY-1:0]     moveSCEN,
   output logic [N_ENEMY-1:0]     damageSCEN,
   output logic [7:0]             damageIn,
   output logic [8:0]             unitFront,
   output logic [8:0]             enemyFront,
   output logic [7:0]             enemyDamage,
   output logic                   busy,
   output logic                   tickDone,
   output logic                   overrun
);

   localparam int IDXW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_ENEMY - 1);
   localparam logic [N_ENEMY-1:0] ONE_HOT0 = N_ENEMY'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_MOVE   = 3'd2,
      S_SETTLE = 3'd3,
      S_ACCUM  = 3'd4,
      S_HIT    = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   // Slot walker and per-round tracking
   logic [IDXW-1:0]      r_idx;
   logic [8:0]           r_best_pos;
   logic [IDXW-1:0]      r_best_idx;
   logic                 r_found;
   logic [8:0]           r_acc;

   // Registered outputs
   logic [N_ENEMY-1:0]   r_move;
   logic [N_ENEMY-1:0]   r_hit;
   logic [7:0]           r_dmg_in;
   logic [8:0]           r_unit_front;
   logic [8:0]           r_enemy_front;
   logic [7:0]           r_enemy_damage;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_overrun;

   // Combinational helpers
   logic [N_ENEMY-1:0]   w_live;
   logic [8:0]           w_sel_pos;
   logic [7:0]           w_sel_dmg;
   logic                 w_sel_live;
   logic                 w_last;
   logic                 w_take;
   logic [8:0]           w_best_pos_nxt;
   logic [IDXW-1:0]      w_best_idx_nxt;
   logic                 w_found_nxt;
   logic [8:0]           w_acc_sum;
   logic [8:0]           w_acc_nxt;
   logic [N_ENEMY-1:0]   w_move_nxt;
   logic [N_ENEMY-1:0]   w_hit_nxt;
   logic [7:0]           w_dmg_in_nxt;
   logic                 w_done_nxt;
   logic                 w_busy_nxt;

   // Live mask: a slot is alive whenever its type field is non-zero
   always_comb begin
      w_live = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         w_live[i] = |enemyType[2*i +: 2];
      end
   end

   // Select the slot currently addressed by the walker
   assign w_sel_pos  = enemyPos[9*int'(r_idx) +: 9];
   assign w_sel_dmg  = enemyDmg[8*int'(r_idx) +: 8];
   assign w_sel_live = w_live[r_idx];
   assign w_last     = (r_idx == LAST_IDX);

   // Front tracking: strictly greater wins, so ties keep the lower index
   always_comb begin
      w_take         = w_sel_live && (!r_found || (w_sel_pos > r_best_pos));
      w_best_pos_nxt = w_take ? w_sel_pos : r_best_pos;
      w_best_idx_nxt = w_take ? r_idx : r_best_idx;
      w_found_nxt    = r_found | w_take;
   end

   // Saturating damage accumulator; 9 bits hold 255 + 255 without wrap
   always_comb begin
      w_acc_sum = r_acc + {1'b0, w_sel_dmg};
      if (!w_sel_live) begin
         w_acc_nxt = r_acc;
      end else if (w_acc_sum > 9'd255) begin
         w_acc_nxt = 9'd255;
      end else begin
         w_acc_nxt = w_acc_sum;
      end
   end

   // Next-state and next-output decode for the round sequencer
   always_comb begin
      w_state_nxt  = r_state;
      w_move_nxt   = '0;
      w_hit_nxt    = '0;
      w_dmg_in_nxt = 8'd0;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (gameTick) begin
               w_state_nxt = S_SCAN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SCAN: begin
            if (w_last) begin
               w_state_nxt = S_MOVE;
            end else begin
               w_state_nxt = S_SCAN;
            end
         end
         S_MOVE: begin
            w_move_nxt  = w_live;
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            w_state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            if (!w_last) begin
               w_state_nxt = S_ACCUM;
            end else if (r_found) begin
               w_state_nxt = S_HIT;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_HIT: begin
            w_hit_nxt    = ONE_HOT0 << r_best_idx;
            w_dmg_in_nxt = playerDamage;
            w_state_nxt  = S_DONE;
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Strobe and status output registers, one cycle behind the state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_move   <= '0;
         r_hit    <= '0;
         r_dmg_in <= 8'd0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_move   <= w_move_nxt;
         r_hit    <= w_hit_nxt;
         r_dmg_in <= w_dmg_in_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Round datapath: slot walker, front tracking, accumulator, results
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx          <= '0;
         r_best_pos     <= 9'd0;
         r_best_idx     <= '0;
         r_found        <= 1'b0;
         r_acc          <= 9'd0;
         r_unit_front   <= 9'd0;
         r_enemy_front  <= 9'd0;
         r_enemy_damage <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (gameTick) begin
                  r_unit_front <= playerFront;
                  r_best_pos   <= 9'd0;
                  r_best_idx   <= '0;
                  r_found      <= 1'b0;
                  r_acc        <= 9'd0;
                  r_idx        <= '0;
               end
            end
            S_SCAN: begin
               r_best_pos <= w_best_pos_nxt;
               r_best_idx <= w_best_idx_nxt;
               r_found    <= w_found_nxt;
               if (w_last) begin
                  r_idx         <= '0;
                  r_enemy_front <= w_found_nxt ? w_best_pos_nxt : 9'd0;
               end else begin
                  r_idx <= r_idx + IDXW'(1);
               end
            end
            S_MOVE, S_SETTLE: begin
               r_idx <= '0;
            end
            S_ACCUM: begin
               r_acc <= w_acc_nxt;
               if (w_last) begin
                  r_idx          <= '0;
                  r_enemy_damage <= w_acc_nxt[7:0];
               end else begin
                  r_idx <= r_idx + IDXW'(1);
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   // Sticky overrun: any tick seen while a round is running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun <= 1'b0;
      end else if (gameTick && (r_state != S_IDLE)) begin
         r_overrun <= 1'b1;
      end
   end

   assign moveSCEN    = r_move;
   assign damageSCEN  = r_hit;
   assign damageIn    = r_dmg_in;
   assign unitFront   = r_unit_front;
   assign enemyFront  = r_enemy_front;
   assign enemyDamage = r_enemy_damage;
   assign busy        = r_busy;
   assign tickDone    = r_done;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_battle_front.sv
// tb_battle_front: scenario tasks for battle_front with N_ENEMY=4.
// Each round's expected results come from a small behavioural model, are
// pushed to a queue when the round is launched and popped after it ends.

module tb_battle_front;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             gameTick;
   logic [8:0]       playerFront;
   logic [7:0]       playerDamage;
   logic [9*N-1:0]   enemyPos;
   logic [8*N-1:0]   enemyDmg;
   logic [2*N-1:0]   enemyType;
   logic [N-1:0]     moveSCEN;
   logic [N-1:0]     damageSCEN;
   logic [7:0]       damageIn;
   logic [8:0]       unitFront;
   logic [8:0]       enemyFront;
   logic [7:0]       enemyDamage;
   logic             busy;
   logic             tickDone;
   logic             overrun;

   logic [1:0]       t_type [N];
   logic [8:0]       t_pos  [N];
   logic [7:0]       t_dmg  [N];

   typedef struct {
      logic [8:0] front;
      logic [7:0] damage;
      logic [3:0] move;
      logic [3:0] hit;
      logic [7:0] dmg_in;
      logic [8:0] ufront;
      int         done_edge;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   int n_checks = 0;
   int n_fails  = 0;

   // Observations from the most recent round
   int         o_move_edge, o_move_cnt, o_hit_edge, o_hit_cnt;
   int         o_done_edge, o_done_cnt, o_busy_fall, o_stray;
   logic [3:0] o_move_val, o_hit_val;
   logic [7:0] o_dmg_in;
   logic [8:0] o_ufront;
   logic       o_busy0;

   always #5 clk = ~clk;

   // Pack the per-slot stimulus arrays onto the DUT buses
   always_comb begin
      enemyPos  = '0;
      enemyDmg  = '0;
      enemyType = '0;
      for (int i = 0; i < N; i++) begin
         enemyPos[9*i +: 9]  = t_pos[i];
         enemyDmg[8*i +: 8]  = t_dmg[i];
         enemyType[2*i +: 2] = t_type[i];
      end
   end

   battle_front #(.N_ENEMY(N)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .gameTick     (gameTick),
      .playerFront  (playerFront),
      .playerDamage (playerDamage),
      .enemyPos     (enemyPos),
      .enemyDmg     (enemyDmg),
      .enemyType    (enemyType),
      .moveSCEN     (moveSCEN),
      .damageSCEN   (damageSCEN),
      .damageIn     (damageIn),
      .unitFront    (unitFront),
      .enemyFront   (enemyFront),
      .enemyDamage  (enemyDamage),
      .busy         (busy),
      .tickDone     (tickDone),
      .overrun      (overrun)
   );

   // Behavioural model of one round from the current slot contents
   function automatic exp_t model_round(input logic [8:0] pf, input logic [7:0] pd);
      exp_t r;
      int   sum;
      int   best;
      int   bidx;
      bit   any;
      sum = 0; best = 0; bidx = 0; any = 1'b0;
      r.move = 4'd0;
      for (int i = 0; i < N; i++) begin
         if (t_type[i] != 2'd0) begin
            r.move[i] = 1'b1;
            sum = sum + int'(t_dmg[i]);
            if (!any || int'(t_pos[i]) > best) begin
               best = int'(t_pos[i]);
               bidx = i;
            end
            any = 1'b1;
         end
      end
      r.front     = any ? 9'(best) : 9'd0;
      r.damage    = (sum > 255) ? 8'd255 : 8'(sum);
      r.hit       = any ? (4'd1 << bidx) : 4'd0;
      r.dmg_in    = pd;
      r.ufront    = pf;
      r.done_edge = any ? (2*N + 4) : (2*N + 3);
      return r;
   endfunction

   task automatic set_slots(input logic [1:0] ty0, ty1, ty2, ty3,
                            input logic [8:0] p0, p1, p2, p3,
                            input logic [7:0] d0, d1, d2, d3);
      t_type[0] = ty0; t_type[1] = ty1; t_type[2] = ty2; t_type[3] = ty3;
      t_pos[0]  = p0;  t_pos[1]  = p1;  t_pos[2]  = p2;  t_pos[3]  = p3;
      t_dmg[0]  = d0;  t_dmg[1]  = d1;  t_dmg[2]  = d2;  t_dmg[3]  = d3;
   endtask

   // Launch one round and record what the DUT does over edges 1..14
   task automatic run_round(input logic [8:0] pf, input logic [7:0] pd, input bit tick3);
      playerFront  = pf;
      playerDamage = pd;
      exp_q.push_back(model_round(pf, pd));
      @(posedge clk); #1;
      gameTick = 1'b1;
      @(posedge clk); #1;
      gameTick    = 1'b0;
      playerFront = ~pf;
      o_busy0 = busy;
      o_move_edge = -1; o_move_cnt = 0; o_move_val = 4'd0;
      o_hit_edge  = -1; o_hit_cnt  = 0; o_hit_val  = 4'd0; o_dmg_in = 8'd0;
      o_done_edge = -1; o_done_cnt = 0; o_busy_fall = -1; o_stray = 0;
      for (int c = 1; c <= 14; c++) begin
         gameTick = (tick3 && c == 3) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         if (moveSCEN != 4'd0) begin
            if (o_move_cnt == 0) begin o_move_edge = c; o_move_val = moveSCEN; end
            o_move_cnt++;
         end
         if (damageSCEN != 4'd0) begin
            if (o_hit_cnt == 0) begin o_hit_edge = c; o_hit_val = damageSCEN; o_dmg_in = damageIn; end
            o_hit_cnt++;
         end
         if (damageSCEN == 4'd0 && damageIn != 8'd0) o_stray++;
         if (tickDone) begin
            if (o_done_cnt == 0) o_done_edge = c;
            o_done_cnt++;
         end
         if (!busy && o_busy_fall < 0) o_busy_fall = c;
      end
      gameTick = 1'b0;
      o_ufront = unitFront;
      e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({moveSCEN, damageSCEN, damageIn, unitFront, enemyFront, enemyDamage, busy, tickDone, overrun} !== '0) begin
         n_fails++;
         $display("FAIL reset_state: got outputs %h expected all zero",
                  {moveSCEN, damageSCEN, damageIn, unitFront, enemyFront, enemyDamage, busy, tickDone, overrun});
      end
      @(negedge clk) reset_n = 1'b1;
      set_slots(2'd1, 2'd2, 2'd3, 2'd1, 9'd7, 9'd70, 9'd30, 9'd12, 8'd9, 8'd9, 8'd9, 8'd9);
      playerFront = 9'h155;
      playerDamage = 8'd77;
      @(posedge clk); #1;
      gameTick = 1'b1;
      @(posedge clk); #1;
      gameTick = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_midround_busy: got %b expected 1", busy);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({moveSCEN, damageSCEN, damageIn, unitFront, enemyFront, enemyDamage, busy, tickDone, overrun} !== '0) begin
         n_fails++;
         $display("FAIL reset_abort: got outputs %h expected all zero",
                  {moveSCEN, damageSCEN, damageIn, unitFront, enemyFront, enemyDamage, busy, tickDone, overrun});
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({moveSCEN, damageSCEN, tickDone, busy} !== '0) begin
         n_fails++;
         $display("FAIL reset_hold: got strobes %h expected 0", {moveSCEN, damageSCEN, tickDone, busy});
      end
      @(negedge clk) reset_n = 1'b1;
      run_round(9'h0AB, 8'd77, 1'b0);
      n_checks++;
      if (o_done_edge !== 12 || o_busy_fall !== 12 || o_busy0 !== 1'b1) begin
         n_fails++;
         $display("FAIL reset_full_round: got done=%0d busyfall=%0d busy0=%b expected 12 12 1",
                  o_done_edge, o_busy_fall, o_busy0);
      end
      n_checks++;
      if (enemyFront !== e.front || enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL reset_round_result: got front=%0d dmg=%0d expected %0d %0d",
                  enemyFront, enemyDamage, e.front, e.damage);
      end
   endtask

   task automatic test_front_select();
      set_slots(2'd1, 2'd1, 2'd0, 2'd1, 9'd10, 9'd40, 9'd99, 9'd40, 8'd5, 8'd6, 8'd7, 8'd8);
      run_round(9'd3, 8'd32, 1'b0);
      n_checks++;
      if (enemyFront !== e.front) begin
         n_fails++;
         $display("FAIL front_value: got %0d expected %0d", enemyFront, e.front);
      end
      n_checks++;
      if (o_hit_val !== e.hit || o_hit_edge !== 2*N+3 || o_hit_cnt !== 1) begin
         n_fails++;
         $display("FAIL front_hit: got mask=%b edge=%0d cnt=%0d expected mask=%b edge=%0d cnt=1",
                  o_hit_val, o_hit_edge, o_hit_cnt, e.hit, 2*N+3);
      end
      n_checks++;
      if (o_dmg_in !== e.dmg_in || o_stray !== 0) begin
         n_fails++;
         $display("FAIL front_damageIn: got %0d stray=%0d expected %0d stray=0", o_dmg_in, o_stray, e.dmg_in);
      end
      n_checks++;
      if (enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL front_enemyDamage: got %0d expected %0d", enemyDamage, e.damage);
      end
   endtask

   task automatic test_move_mask();
      set_slots(2'd0, 2'd1, 2'd2, 2'd0, 9'd1, 9'd2, 9'd3, 9'd4, 8'd0, 8'd0, 8'd0, 8'd0);
      run_round(9'h1A5, 8'd1, 1'b0);
      n_checks++;
      if (o_move_val !== e.move || o_move_edge !== N+1 || o_move_cnt !== 1) begin
         n_fails++;
         $display("FAIL move_mask: got mask=%b edge=%0d cnt=%0d expected mask=%b edge=%0d cnt=1",
                  o_move_val, o_move_edge, o_move_cnt, e.move, N+1);
      end
      n_checks++;
      if (o_ufront !== e.ufront) begin
         n_fails++;
         $display("FAIL move_unitFront: got %h expected %h", o_ufront, e.ufront);
      end
      n_checks++;
      if (o_done_edge !== e.done_edge || o_done_cnt !== 1) begin
         n_fails++;
         $display("FAIL move_tickDone: got edge=%0d cnt=%0d expected edge=%0d cnt=1",
                  o_done_edge, o_done_cnt, e.done_edge);
      end
   endtask

   task automatic test_saturation();
      set_slots(2'd1, 2'd2, 2'd3, 2'd1, 9'd5, 9'd6, 9'd7, 9'd8, 8'd128, 8'd128, 8'd128, 8'd128);
      run_round(9'd20, 8'd2, 1'b0);
      n_checks++;
      if (enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL sat_255: got %0d expected %0d", enemyDamage, e.damage);
      end
      set_slots(2'd1, 2'd1, 2'd1, 2'd1, 9'd5, 9'd6, 9'd7, 9'd8, 8'd32, 8'd0, 8'd0, 8'd64);
      run_round(9'd20, 8'd2, 1'b0);
      n_checks++;
      if (enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL sat_96: got %0d expected %0d", enemyDamage, e.damage);
      end
   endtask

   task automatic test_empty();
      set_slots(2'd0, 2'd0, 2'd0, 2'd0, 9'd50, 9'd60, 9'd70, 9'd80, 8'd10, 8'd20, 8'd30, 8'd40);
      run_round(9'd9, 8'd44, 1'b0);
      n_checks++;
      if (enemyFront !== e.front || enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL empty_result: got front=%0d dmg=%0d expected %0d %0d",
                  enemyFront, enemyDamage, e.front, e.damage);
      end
      n_checks++;
      if (o_hit_cnt !== 0 || o_move_cnt !== 0 || o_stray !== 0) begin
         n_fails++;
         $display("FAIL empty_strobes: got hit=%0d move=%0d stray=%0d expected 0 0 0",
                  o_hit_cnt, o_move_cnt, o_stray);
      end
      n_checks++;
      if (o_done_edge !== e.done_edge || o_busy_fall !== 2*N+3) begin
         n_fails++;
         $display("FAIL empty_timing: got done=%0d busyfall=%0d expected %0d %0d",
                  o_done_edge, o_busy_fall, e.done_edge, 2*N+3);
      end
   endtask

   task automatic test_overrun();
      n_checks++;
      if (overrun !== 1'b0) begin
         n_fails++;
         $display("FAIL overrun_pre: got %b expected 0", overrun);
      end
      set_slots(2'd3, 2'd1, 2'd2, 2'd1, 9'd100, 9'd200, 9'd150, 9'd201, 8'd1, 8'd2, 8'd3, 8'd4);
      run_round(9'd66, 8'd99, 1'b1);
      n_checks++;
      if (overrun !== 1'b1) begin
         n_fails++;
         $display("FAIL overrun_set: got %b expected 1", overrun);
      end
      n_checks++;
      if (o_done_edge !== e.done_edge || o_done_cnt !== 1 || o_hit_val !== e.hit || o_hit_cnt !== 1) begin
         n_fails++;
         $display("FAIL overrun_round: got done=%0d cnt=%0d hit=%b hcnt=%0d expected done=%0d cnt=1 hit=%b hcnt=1",
                  o_done_edge, o_done_cnt, o_hit_val, o_hit_cnt, e.done_edge, e.hit);
      end
      n_checks++;
      if (enemyFront !== e.front || enemyDamage !== e.damage) begin
         n_fails++;
         $display("FAIL overrun_result: got front=%0d dmg=%0d expected %0d %0d",
                  enemyFront, enemyDamage, e.front, e.damage);
      end
      run_round(9'd67, 8'd5, 1'b0);
      n_checks++;
      if (overrun !== 1'b1 || o_done_edge !== e.done_edge) begin
         n_fails++;
         $display("FAIL overrun_sticky: got overrun=%b done=%0d expected 1 %0d", overrun, o_done_edge, e.done_edge);
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      gameTick     = 1'b0;
      playerFront  = 9'd0;
      playerDamage = 8'd0;
      set_slots(2'd0, 2'd0, 2'd0, 2'd0, 9'd0, 9'd0, 9'd0, 9'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      test_reset();
      test_front_select();
      test_move_mask();
      test_saturation();
      test_empty();
      test_overrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
